// File: rtl/cpu_fetch.sv
// cpu_fetch: Wishbone fetch stage that realigns halfword branch targets into a 32-bit FIFO stream.
// Define CPU_FETCH_BUSERR_EN to halt with fault_o on wb_err_i.
module cpu_fetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        newPC_p_i,
  input  logic [31:0] PC_i,
  input  logic        full_i,
  output logic        write_en_o,
  output logic [31:0] data_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        fault_o
);
`ifdef CPU_FETCH_BUSERR_EN
  typedef enum logic [1:0] {IDLE, BUS_REQ, FLUSH, HALT} state_e;
`else
  typedef enum logic [1:0] {IDLE, BUS_REQ, FLUSH} state_e;
`endif
  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d, data_q, data_d;
  logic [15:0] half_q, half_d;
  logic        wen_q, wen_d, hv_q, hv_d, skip_q, skip_d, cyc_q, cyc_d;
  logic        ack, err, done, accept;
  // cyc_q gates the bus responses so an ack from a cycle abandoned by reset is ignored
  assign ack = wb_ack_i & cyc_q;
`ifdef CPU_FETCH_BUSERR_EN
  assign err = wb_err_i & cyc_q & ~wb_ack_i;
  assign fault_o = state_q == HALT;
`else
  logic unused_err;
  assign unused_err = wb_err_i;
  assign err = 1'b0;
  assign fault_o = 1'b0;
`endif
  assign done = ack | err;
  assign write_en_o = wen_q & ~newPC_p_i;
  assign accept = write_en_o & ~full_i;
  assign data_o = data_q;
  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    data_d = data_q;
    half_d = half_q;
    hv_d = hv_q;
    skip_d = skip_q;
    wen_d = wen_q & ~accept;
    if (newPC_p_i) begin
      state_d = (cyc_q && !done) ? FLUSH : BUS_REQ;
      adr_d = {PC_i[31:2], 2'b00};
      hv_d = 1'b0;
      skip_d = PC_i[1];
      wen_d = 1'b0;
    end else if (state_q == BUS_REQ && ack) begin
      adr_d = adr_q + 32'd4;
      half_d = wb_dat_i[15:0];
      hv_d = hv_q | skip_q;
      skip_d = 1'b0;
      wen_d = ~skip_q;
      data_d = skip_q ? data_q : hv_q ? {half_q, wb_dat_i[31:16]} : wb_dat_i;
      state_d = skip_q ? BUS_REQ : IDLE;
`ifdef CPU_FETCH_BUSERR_EN
    end else if (state_q == BUS_REQ && err) begin
      state_d = HALT;
`endif
    end else if (state_q == FLUSH && done) begin
      state_d = BUS_REQ;
    end else if (state_q == IDLE && (!wen_q || accept)) begin
      state_d = BUS_REQ;
    end
    cyc_d = state_d == BUS_REQ || state_d == FLUSH;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BUS_REQ;
      adr_q <= {BOOT_ADDRESS[31:2], 2'b00};
      data_q <= 32'd0;
      half_q <= 16'd0;
      hv_q <= 1'b0;
      skip_q <= BOOT_ADDRESS[1];
      wen_q <= 1'b0;
      cyc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      data_q <= data_d;
      half_q <= half_d;
      hv_q <= hv_d;
      skip_q <= skip_d;
      wen_q <= wen_d;
      cyc_q <= cyc_d;
    end
  end
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: random Wishbone responder and FIFO back-pressure against a halfword-stream model.
module tb_cpu_fetch;
  localparam logic [31:0] BOOT = 32'h00001000;
  logic clk = 1'b0;
  logic rst, newpc, full, ack, err, wen, cyc, stb, fault;
  logic [31:0] pc, dat, dout, adr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cpu_fetch #(.BOOT_ADDRESS(BOOT)) dut (
    .clk_i(clk), .rst_i(rst), .newPC_p_i(newpc), .PC_i(pc), .full_i(full),
    .write_en_o(wen), .data_o(dout), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_adr_o(adr),
    .wb_dat_i(dat), .wb_ack_i(ack), .wb_err_i(err), .fault_o(fault)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h00001000: return 32'h01020304;
      32'h00001004: return 32'h05060708;
      32'h00002000: return 32'hAAAABBBB;
      32'h00002004: return 32'hCCCCDDDD;
      32'h00002008: return 32'hEEEEFFFF;
      32'h00003000: return 32'h30303030;
      32'hFFFFFFF8: return 32'h11112222;
      32'hFFFFFFFC: return 32'h33334444;
      32'h00000000: return 32'h55556666;
      default:      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endcase
  endfunction
  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem({a[31:2], 2'b00});
    return a[1] ? w[15:0] : w[31:16];
  endfunction
  // k-th word of the instruction stream that starts at halfword address b
  function automatic logic [31:0] exp_word(input logic [31:0] b, input int k);
    logic [31:0] a;
    a = b + 32'(4 * k);
    return {hw(a), hw(a + 32'd2)};
  endfunction
  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // bus responder: per-request wait states, optional error address
  int cnt = 0, w = 0, wmax = 0, force_w = -1;
  logic [31:0] err_adr = 32'hFFFFFFFF;
  initial begin
    ack = 1'b0;
    err = 1'b0;
    dat = 32'd0;
  end
  always @(posedge clk) begin
    #1;
    if (ack || err || !stb) cnt = 0;
    ack = 1'b0;
    err = 1'b0;
    dat = $urandom();
    if (stb) begin
      if (cnt == 0) w = (force_w >= 0) ? force_w : int'($urandom_range(0, wmax));
      if (cnt >= w) begin
        if (adr == err_adr) err = 1'b1;
        else begin
          ack = 1'b1;
          dat = mem(adr);
        end
      end
      cnt++;
    end
  end
  // model: stream base, words written, words fetched, pending discard
  logic [31:0] base, prev_data;
  logic discard, prev_stall;
  int k, j, cyc_n = 0, nwr = 0;
  logic [31:0] wr_log[$], adr_log[$];
  int wr_cyc[$];
  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      base = {BOOT[31:1], 1'b0};
      k = 0;
      j = 0;
      discard = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("adr_align", {30'd0, adr[1:0]}, 32'd0);
      chk("cyc_eq_stb", {31'd0, cyc}, {31'd0, stb});
      chk("no_stb_with_word", {31'd0, wen & stb}, 32'd0);
`ifndef CPU_FETCH_BUSERR_EN
      chk("fault_zero", {31'd0, fault}, 32'd0);
`endif
      if (prev_stall && !newpc) begin
        chk("stall_wen", {31'd0, wen}, 32'd1);
        chk("stall_data", dout, prev_data);
      end
      prev_stall = wen && full && !newpc;
      prev_data = dout;
      if (newpc) begin
        chk("newpc_blocks_write", {31'd0, wen}, 32'd0);
        discard = stb && !(ack || err);
        base = {pc[31:1], 1'b0};
        k = 0;
        j = 0;
      end else begin
        if (wen && !full) begin
          chk("wr_data", dout, exp_word(base, k));
          wr_log.push_back(dout);
          wr_cyc.push_back(cyc_n);
          k++;
          nwr++;
        end
        if (stb && (ack || err)) begin
          if (discard) discard = 1'b0;
          else if (ack) begin
            chk("fetch_adr", adr, {base[31:2], 2'b00} + 32'(4 * j));
            adr_log.push_back(adr);
            j++;
          end
        end
      end
    end
  end
  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    adr_log.delete();
  endtask
  task automatic wait_wen();
    int n = 0;
    while (!wen && n < 40) begin
      tick(1);
      n++;
    end
    chk("wen_seen", {31'd0, wen}, 32'd1);
  endtask
  initial begin
    logic [31:0] d0, a0;
    int nlog, n;
    rst = 1'b1;
    newpc = 1'b0;
    pc = 32'd0;
    full = 1'b0;
    tick(3);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_adr", adr, 32'h00001000);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    clear_logs();
    tick(10);
    chk("boot_adr0", qat(adr_log, 0), 32'h00001000);
    chk("boot_adr1", qat(adr_log, 1), 32'h00001004);
    chk("boot_word0", qat(wr_log, 0), 32'h01020304);
    chk("boot_word1", qat(wr_log, 1), 32'h05060708);
    chk("throughput", 32'(wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1), 32'd2);
    newpc = 1'b1;
    pc = 32'h00002002;
    clear_logs();
    tick(1);
    newpc = 1'b0;
    tick(12);
    chk("unal_adr0", qat(adr_log, 0), 32'h00002000);
    chk("unal_adr1", qat(adr_log, 1), 32'h00002004);
    chk("unal_word0", qat(wr_log, 0), 32'hBBBBCCCC);
    chk("unal_word1", qat(wr_log, 1), 32'hDDDDEEEE);
    wait_wen();
    full = 1'b1;
    d0 = dout;
    nlog = wr_log.size();
    repeat (5) begin
      tick(1);
      chk("stall_hold", dout, d0);
      chk("stall_nostb", {31'd0, stb}, 32'd0);
    end
    full = 1'b0;
    a0 = adr;
    tick(1);
    chk("stall_release_write", 32'(wr_log.size()), 32'(nlog + 1));
    chk("stall_release_stb", {31'd0, stb}, 32'd1);
    chk("stall_release_adr", adr, a0);
    rst = 1'b1;
    force_w = 3;
    tick(2);
    rst = 1'b0;
    n = 0;
    while (!(stb && adr == 32'h00001008) && n < 60) begin
      tick(1);
      n++;
    end
    chk("flush_req_seen", {31'd0, stb && adr == 32'h00001008}, 32'd1);
    newpc = 1'b1;
    pc = 32'h00003000;
    clear_logs();
    tick(1);
    newpc = 1'b0;
    chk("flush_stb", {31'd0, stb}, 32'd1);
    chk("flush_adr", adr, 32'h00003000);
    tick(20);
    chk("flush_next_adr", qat(adr_log, 0), 32'h00003000);
    chk("flush_next_word", qat(wr_log, 0), 32'h30303030);
    force_w = -1;
    wait_wen();
    newpc = 1'b1;
    pc = 32'h00002002;
    nlog = wr_log.size();
    #1;
    chk("newpc_gate_comb", {31'd0, wen}, 32'd0);
    tick(1);
    newpc = 1'b0;
    chk("newpc_gate_nolog", 32'(wr_log.size()), 32'(nlog));
    chk("newpc_gate_wen", {31'd0, wen}, 32'd0);
    tick(10);
    newpc = 1'b1;
    pc = 32'hFFFFFFFA;
    clear_logs();
    tick(1);
    newpc = 1'b0;
    tick(14);
    chk("wrap_adr0", qat(adr_log, 0), 32'hFFFFFFF8);
    chk("wrap_adr1", qat(adr_log, 1), 32'hFFFFFFFC);
    chk("wrap_adr2", qat(adr_log, 2), 32'h00000000);
    chk("wrap_word0", qat(wr_log, 0), 32'h22223333);
    chk("wrap_word1", qat(wr_log, 1), 32'h44445555);
`ifdef CPU_FETCH_BUSERR_EN
    err_adr = 32'h00001004;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n = 0;
    while (!fault && n < 30) begin
      tick(1);
      n++;
    end
    chk("err_fault", {31'd0, fault}, 32'd1);
    tick(2);
    chk("err_halt_cyc", {31'd0, cyc}, 32'd0);
    chk("err_halt_wen", {31'd0, wen}, 32'd0);
    err_adr = 32'hFFFFFFFF;
    newpc = 1'b1;
    pc = 32'h00001000;
    clear_logs();
    tick(1);
    newpc = 1'b0;
    chk("err_cleared", {31'd0, fault}, 32'd0);
    tick(10);
    chk("err_resume_word", qat(wr_log, 0), 32'h01020304);
`endif
    wmax = 3;
    repeat (3000) begin
      full = $urandom_range(0, 9) < 3;
      newpc = $urandom_range(0, 99) < 3;
      rst = $urandom_range(0, 999) == 0;
      pc = $urandom();
      pc[0] = 1'b0;
      if ($urandom_range(0, 3) == 0) pc[31:4] = '1;
      tick(1);
    end
    rst = 1'b0;
    newpc = 1'b0;
    full = 1'b0;
    tick(20);
    chk("progress", {31'd0, nwr > 200}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
